// File: rtl/usb_packet_receiver_pkg.sv
// Shared encodings for the USB packet receiver: line states, FSM states,
// error codes, PID bytes, CRC16 constants and the SYNC pattern.
package usb_packet_receiver_pkg;

    typedef enum logic [1:0] {
        BUS_SE0 = 2'b00,
        BUS_K   = 2'b01,
        BUS_J   = 2'b10,
        BUS_SE1 = 2'b11
    } bus_state_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SYNC = 3'd1,
        ST_SYNC      = 3'd2,
        ST_PID       = 3'd3,
        ST_PAYLOAD   = 3'd4,
        ST_EOP       = 3'd5,
        ST_REPORT    = 3'd6
    } rx_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_PID     = 3'd1,
        ERR_STUFF   = 3'd2,
        ERR_CRC     = 3'd3,
        ERR_LENGTH  = 3'd4,
        ERR_BUS     = 3'd5,
        ERR_TIMEOUT = 3'd6
    } pkt_err_t;

    localparam logic [7:0]  PID_ACK        = 8'hD2;
    localparam logic [7:0]  PID_NAK        = 8'h5A;
    localparam logic [7:0]  PID_DATA0      = 8'hC3;
    localparam logic [7:0]  PID_DATA1      = 8'h4B;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    // Bit i is the i-th decoded SYNC bit: seven 0s followed by a 1.
    localparam logic [7:0]  SYNC_PATTERN   = 8'h80;
    localparam logic [2:0]  STUFF_LIMIT    = 3'd6;

    // A PID byte is accepted only if its check nibble matches and it is a supported handshake/data PID.
    function automatic logic pid_is_valid(input logic [7:0] pid);
        logic known;
        known = (pid == PID_ACK) || (pid == PID_NAK) ||
                (pid == PID_DATA0) || (pid == PID_DATA1);
        return (pid[7:4] == ~pid[3:0]) && known;
    endfunction

    // One serial step of CRC16 (x^16+x^15+x^2+1), MSB-side feedback.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic [15:0] shifted;
        shifted = {crc[14:0], 1'b0};
        if (bit_in ^ crc[15]) begin
            return shifted ^ CRC16_POLY;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/usb_rx_crc16.sv
// Serial CRC16 checker: clear loads the seed, enable folds in one bit per clock.
module usb_rx_crc16
    import usb_packet_receiver_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] residual
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: seed on clear, advance on enable, otherwise hold.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC16_INIT;
        end else if (enable) begin
            crc_d = crc16_step(crc_q, bit_in);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign residual = crc_q;

endmodule

// File: rtl/usb_packet_receiver.sv
// USB device-response receiver: NRZI decode, bit unstuffing, packet FSM and
// registered one-cycle packet report.
module usb_packet_receiver
    import usb_packet_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DATA_BITS      = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 dp,
    input  logic                 dm,
    input  logic                 rx_enable,
    output logic                 rx_busy,
    output logic                 pkt_valid,
    output logic [3:0]           pkt_pid,
    output logic [DATA_BITS-1:0] pkt_data,
    output logic [2:0]           pkt_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(DATA_BITS + 17);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] DATA_LIMIT    = CW'(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT      = CW'(DATA_BITS + 15);

    rx_state_t            state_q, state_d;
    bus_state_t           prev_q, prev_d;
    logic [TW-1:0]        timeout_q, timeout_d;
    logic [2:0]           ones_q, ones_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           eop_cnt_q, eop_cnt_d;
    logic [7:0]           pid_q, pid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 is_data_q, is_data_d;
    logic                 done_q, done_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 pkt_valid_q, pkt_valid_d;
    logic [3:0]           pkt_pid_q, pkt_pid_d;
    logic [DATA_BITS-1:0] pkt_data_q, pkt_data_d;
    pkt_err_t             pkt_err_q, pkt_err_d;

    bus_state_t           line_s;
    logic                 bit_s;
    logic                 stuff_s;
    logic [TW-1:0]        timeout_next_s;
    logic                 crc_clear_s;
    logic                 crc_en_s;
    logic [15:0]          crc_residual_s;
    logic                 report_s;
    pkt_err_t             err_s;

    assign line_s         = bus_state_t'({dp, dm});
    assign bit_s          = (line_s == prev_q);
    assign stuff_s        = (ones_q == STUFF_LIMIT);
    assign timeout_next_s = timeout_q + {{(TW-1){1'b0}}, 1'b1};

    usb_rx_crc16 u_crc (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (crc_clear_s),
        .enable   (crc_en_s),
        .bit_in   (bit_s),
        .residual (crc_residual_s)
    );

    // Packet FSM: decode one line sample per clock and decide next state or report.
    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        ones_d      = ones_q;
        bit_cnt_d   = bit_cnt_q;
        eop_cnt_d   = eop_cnt_q;
        pid_d       = pid_q;
        data_d      = data_q;
        is_data_d   = is_data_q;
        done_d      = done_q;
        crc_clear_s = 1'b0;
        crc_en_s    = 1'b0;
        report_s    = 1'b0;
        err_s       = ERR_NONE;
        if (line_s == BUS_J || line_s == BUS_K) begin
            prev_d = line_s;
        end else begin
            prev_d = prev_q;
        end

        case (state_q)
            ST_IDLE: begin
                prev_d    = BUS_J;
                timeout_d = '0;
                ones_d    = 3'd0;
                if (rx_enable && !done_q) begin
                    state_d = ST_WAIT_SYNC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_SYNC: begin
                if (line_s == BUS_SE1) begin
                    report_s = 1'b1;
                    err_s    = ERR_BUS;
                end else if (line_s == BUS_K) begin
                    // First K decodes as the leading 0 of SYNC.
                    state_d   = ST_SYNC;
                    bit_cnt_d = CW'(1);
                end else if (line_s == BUS_J) begin
                    if (timeout_next_s == TIMEOUT_LIMIT) begin
                        report_s = 1'b1;
                        err_s    = ERR_TIMEOUT;
                    end else begin
                        timeout_d = timeout_next_s;
                    end
                end else begin
                    timeout_d = timeout_q;
                end
            end
            ST_SYNC: begin
                if (line_s == BUS_SE1) begin
                    report_s = 1'b1;
                    err_s    = ERR_BUS;
                end else if (line_s == BUS_SE0 || bit_s != SYNC_PATTERN[bit_cnt_q[2:0]]) begin
                    // Not a real SYNC: drop it quietly and hunt again.
                    state_d = ST_WAIT_SYNC;
                    prev_d  = BUS_J;
                end else if (bit_cnt_q == CW'(7)) begin
                    state_d     = ST_PID;
                    bit_cnt_d   = '0;
                    ones_d      = 3'd0;
                    pid_d       = 8'd0;
                    data_d      = '0;
                    is_data_d   = 1'b0;
                    crc_clear_s = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            ST_PID: begin
                if (line_s == BUS_SE1) begin
                    report_s = 1'b1;
                    err_s    = ERR_BUS;
                end else if (line_s == BUS_SE0) begin
                    report_s = 1'b1;
                    err_s    = ERR_LENGTH;
                end else if (stuff_s) begin
                    if (bit_s) begin
                        report_s = 1'b1;
                        err_s    = ERR_STUFF;
                    end else begin
                        ones_d = 3'd0;
                    end
                end else begin
                    ones_d = bit_s ? (ones_q + 3'd1) : 3'd0;
                    pid_d  = {bit_s, pid_q[7:1]};
                    if (bit_cnt_q == CW'(7)) begin
                        bit_cnt_d = '0;
                        eop_cnt_d = 2'd0;
                        if (!pid_is_valid(pid_d)) begin
                            report_s = 1'b1;
                            err_s    = ERR_PID;
                        end else if (pid_d == PID_DATA0 || pid_d == PID_DATA1) begin
                            state_d   = ST_PAYLOAD;
                            is_data_d = 1'b1;
                        end else begin
                            state_d = ST_EOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (line_s == BUS_SE1) begin
                    report_s = 1'b1;
                    err_s    = ERR_BUS;
                end else if (line_s == BUS_SE0) begin
                    report_s = 1'b1;
                    err_s    = ERR_LENGTH;
                end else if (stuff_s) begin
                    if (bit_s) begin
                        report_s = 1'b1;
                        err_s    = ERR_STUFF;
                    end else begin
                        ones_d = 3'd0;
                    end
                end else begin
                    ones_d   = bit_s ? (ones_q + 3'd1) : 3'd0;
                    crc_en_s = 1'b1;
                    // Only the data field is kept; the trailing 16 CRC bits just feed the checker.
                    if (bit_cnt_q < DATA_LIMIT) begin
                        data_d = {bit_s, data_q[DATA_BITS-1:1]};
                    end else begin
                        data_d = data_q;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_EOP;
                        eop_cnt_d = 2'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            ST_EOP: begin
                if (line_s == BUS_SE1) begin
                    report_s = 1'b1;
                    err_s    = ERR_BUS;
                end else if (stuff_s && line_s != BUS_SE0) begin
                    // A stuff bit may still follow the final CRC bit.
                    if (bit_s) begin
                        report_s = 1'b1;
                        err_s    = ERR_STUFF;
                    end else begin
                        ones_d = 3'd0;
                    end
                end else if (eop_cnt_q == 2'd2) begin
                    report_s = 1'b1;
                    if (line_s == BUS_J) begin
                        err_s = ERR_NONE;
                    end else begin
                        err_s = ERR_LENGTH;
                    end
                end else if (eop_cnt_q == 2'd0 && is_data_q && crc_residual_s != CRC16_RESIDUAL) begin
                    report_s = 1'b1;
                    err_s    = ERR_CRC;
                end else if (line_s != BUS_SE0) begin
                    report_s = 1'b1;
                    err_s    = ERR_LENGTH;
                end else begin
                    eop_cnt_d = eop_cnt_q + 2'd1;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping rx_enable wins over everything, including a pending report.
        if (!rx_enable) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end else if (report_s) begin
            state_d = ST_REPORT;
            done_d  = 1'b1;
        end else begin
            done_d = done_q;
        end
    end

    // Output register inputs: report fields load only when a report is being issued.
    always_comb begin
        rx_busy_d   = (state_d != ST_IDLE);
        pkt_valid_d = (state_d == ST_REPORT);
        pkt_pid_d   = pkt_pid_q;
        pkt_data_d  = pkt_data_q;
        pkt_err_d   = pkt_err_q;
        if (pkt_valid_d) begin
            pkt_err_d = err_s;
            if (err_s == ERR_TIMEOUT) begin
                pkt_pid_d  = 4'd0;
                pkt_data_d = '0;
            end else begin
                pkt_pid_d  = pid_d[3:0];
                pkt_data_d = data_d;
            end
        end else begin
            pkt_err_d = pkt_err_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            prev_q      <= BUS_J;
            timeout_q   <= '0;
            ones_q      <= 3'd0;
            bit_cnt_q   <= '0;
            eop_cnt_q   <= 2'd0;
            pid_q       <= 8'd0;
            data_q      <= '0;
            is_data_q   <= 1'b0;
            done_q      <= 1'b0;
            rx_busy_q   <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_pid_q   <= 4'd0;
            pkt_data_q  <= '0;
            pkt_err_q   <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            timeout_q   <= timeout_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            eop_cnt_q   <= eop_cnt_d;
            pid_q       <= pid_d;
            data_q      <= data_d;
            is_data_q   <= is_data_d;
            done_q      <= done_d;
            rx_busy_q   <= rx_busy_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_pid_q   <= pkt_pid_d;
            pkt_data_q  <= pkt_data_d;
            pkt_err_q   <= pkt_err_d;
        end
    end

    assign rx_busy   = rx_busy_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_pid   = pkt_pid_q;
    assign pkt_data  = pkt_data_q;
    assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_usb_packet_receiver.sv
// Directed bench for usb_packet_receiver: drives NRZI/stuffed packets and
// checks reports with immediate assertions.
module tb_usb_packet_receiver;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;
    localparam logic [1:0] LSE1 = 2'b11;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        dp, dm;
    logic        rx_enable;
    logic        rx_busy;
    logic        pkt_valid;
    logic [3:0]  pkt_pid;
    logic [63:0] pkt_data;
    logic [2:0]  pkt_err;

    int n_tests = 0;
    int n_fail  = 0;
    int vcount  = 0;
    int v0;
    logic [3:0]  cap_pid;
    logic [2:0]  cap_err;
    logic [1:0]  cur;
    int          ones;
    logic        bad_stuff;
    logic [63:0] dat;
    logic [15:0] crc;

    usb_packet_receiver #(.TIMEOUT_CYCLES(255), .DATA_BITS(64)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .dp        (dp),
        .dm        (dm),
        .rx_enable (rx_enable),
        .rx_busy   (rx_busy),
        .pkt_valid (pkt_valid),
        .pkt_pid   (pkt_pid),
        .pkt_data  (pkt_data),
        .pkt_err   (pkt_err)
    );

    always #5 clock = ~clock;

    // Report monitor, sampled shortly after each rising edge.
    always @(posedge clock) begin
        #2;
        if (pkt_valid === 1'b1) begin
            vcount  = vcount + 1;
            cap_pid = pkt_pid;
            cap_err = pkt_err;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_sym(input logic [1:0] s);
        @(negedge clock);
        {dp, dm} = s;
    endtask

    task automatic send_bit(input logic b);
        if (!b) cur = (cur == LJ) ? LK : LJ;
        send_sym(cur);
    endtask

    // Send one payload/PID bit, inserting a stuff bit after six 1s.
    task automatic send_ubit(input logic b);
        send_bit(b);
        if (b) ones++; else ones = 0;
        if (ones == 6) begin
            send_bit(bad_stuff);
            bad_stuff = 1'b0;
            ones = 0;
        end
    endtask

    task automatic send_sync();
        cur = LJ;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
        ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_ubit(v[i]);
    endtask

    task automatic send_data(input logic [63:0] d, input int nbits, input logic [15:0] c);
        for (int i = 0; i < nbits; i++) send_ubit(d[i]);
        if (nbits == 64) begin
            for (int i = 15; i >= 0; i--) send_ubit(~c[i]);
        end
    endtask

    task automatic send_eop();
        send_sym(LSE0);
        send_sym(LSE0);
        send_sym(LJ);
        cur = LJ;
    endtask

    task automatic start_rx();
        @(negedge clock);
        rx_enable = 1'b1;
        {dp, dm} = LJ;
        send_sym(LJ);
        send_sym(LJ);
        v0 = vcount;
    endtask

    task automatic stop_rx();
        @(negedge clock);
        rx_enable = 1'b0;
        {dp, dm} = LJ;
        cur = LJ;
        repeat (2) @(negedge clock);
    endtask

    function automatic logic [15:0] crc16(input logic [63:0] d);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            fb = d[i] ^ c[15];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    initial begin
        reset_n   = 1'b0;
        rx_enable = 1'b0;
        {dp, dm}  = LJ;
        cur       = LJ;
        ones      = 0;
        bad_stuff = 1'b0;
        dat       = 64'h0000FFFF0000FFFF;
        crc       = crc16(dat);
        #12;
        check("reset_busy",  {63'd0, rx_busy},   64'd0);
        check("reset_valid", {63'd0, pkt_valid}, 64'd0);
        check("reset_pid",   {60'd0, pkt_pid},   64'd0);
        check("reset_data",  pkt_data,           64'd0);
        check("reset_err",   {61'd0, pkt_err},   64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // ACK with exact report timing
        start_rx();
        check("busy_wait_sync", {63'd0, rx_busy}, 64'd1);
        send_sync();
        send_byte(8'hD2);
        send_eop();
        @(negedge clock);
        check("ack_valid", {63'd0, pkt_valid}, 64'd1);
        check("ack_pid",   {60'd0, pkt_pid},   64'd2);
        check("ack_err",   {61'd0, pkt_err},   64'd0);
        @(negedge clock);
        check("ack_valid_one_cycle", {63'd0, pkt_valid}, 64'd0);

        // No second report until rx_enable is cycled
        v0 = vcount;
        send_sync();
        send_byte(8'hD2);
        send_eop();
        repeat (2) @(negedge clock);
        check("rearm_no_report", vcount, v0);
        check("rearm_idle_busy", {63'd0, rx_busy}, 64'd0);
        stop_rx();

        // DATA0 with valid CRC
        start_rx();
        send_sync();
        send_byte(8'hC3);
        send_data(dat, 64, crc);
        send_eop();
        @(negedge clock);
        check("data0_valid", {63'd0, pkt_valid}, 64'd1);
        check("data0_pid",   {60'd0, pkt_pid},   64'd3);
        check("data0_data",  pkt_data,           64'h0000FFFF0000FFFF);
        check("data0_err",   {61'd0, pkt_err},   64'd0);
        stop_rx();

        // Payload bit 5 flipped, original CRC
        start_rx();
        send_sync();
        send_byte(8'hC3);
        send_data(64'h0000FFFF0000FFDF, 64, crc);
        send_eop();
        repeat (2) @(negedge clock);
        check("crc_count", vcount, v0 + 1);
        check("crc_err",   {61'd0, cap_err}, 64'd3);
        stop_rx();

        // First stuff bit sent as 1
        start_rx();
        bad_stuff = 1'b1;
        send_sync();
        send_byte(8'hC3);
        send_data(dat, 64, crc);
        send_eop();
        repeat (2) @(negedge clock);
        check("stuff_count", vcount, v0 + 1);
        check("stuff_err",   {61'd0, cap_err}, 64'd2);
        check("stuff_pid",   {60'd0, cap_pid}, 64'd3);
        stop_rx();

        // SE0 after 40 payload bits
        start_rx();
        send_sync();
        send_byte(8'hC3);
        send_data(dat, 40, crc);
        send_eop();
        repeat (2) @(negedge clock);
        check("length_count", vcount, v0 + 1);
        check("length_err",   {61'd0, cap_err}, 64'd4);
        check("length_pid",   {60'd0, cap_pid}, 64'd3);

        // Reset mid-payload, outputs clear immediately
        stop_rx();
        start_rx();
        send_sync();
        send_byte(8'hC3);
        send_data(dat, 20, crc);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_busy",  {63'd0, rx_busy},   64'd0);
        check("rst_valid", {63'd0, pkt_valid}, 64'd0);
        check("rst_pid",   {60'd0, pkt_pid},   64'd0);
        check("rst_data",  pkt_data,           64'd0);
        check("rst_err",   {61'd0, pkt_err},   64'd0);
        rx_enable = 1'b0;
        {dp, dm}  = LJ;
        cur       = LJ;
        ones      = 0;
        @(negedge clock);
        reset_n = 1'b1;

        // NAK after reset
        start_rx();
        send_sync();
        send_byte(8'h5A);
        send_eop();
        @(negedge clock);
        check("nak_valid", {63'd0, pkt_valid}, 64'd1);
        check("nak_pid",   {60'd0, pkt_pid},   64'd10);
        check("nak_err",   {61'd0, pkt_err},   64'd0);
        stop_rx();

        // Bad PID check nibble
        start_rx();
        send_sync();
        send_byte(8'hD3);
        repeat (2) @(negedge clock);
        check("pid_count", vcount, v0 + 1);
        check("pid_err",   {61'd0, cap_err}, 64'd1);
        check("pid_pid",   {60'd0, cap_pid}, 64'd3);
        stop_rx();

        // SE1 during SYNC
        start_rx();
        send_bit(1'b0);
        send_bit(1'b0);
        send_sym(LSE1);
        @(negedge clock);
        check("bus_valid", {63'd0, pkt_valid}, 64'd1);
        check("bus_err",   {61'd0, pkt_err},   64'd5);
        stop_rx();

        // Abort mid-PID
        start_rx();
        send_sync();
        for (int i = 0; i < 4; i++) send_ubit(1'b1);
        @(negedge clock);
        rx_enable = 1'b0;
        @(negedge clock);
        check("abort_busy", {63'd0, rx_busy}, 64'd0);
        repeat (3) @(negedge clock);
        check("abort_no_report", vcount, v0);
        {dp, dm} = LJ;
        cur = LJ;

        // Timeout after 255 idle samples
        @(negedge clock);
        rx_enable = 1'b1;
        repeat (255) @(negedge clock);
        check("timeout_early", {63'd0, pkt_valid}, 64'd0);
        @(negedge clock);
        check("timeout_valid", {63'd0, pkt_valid}, 64'd1);
        check("timeout_err",   {61'd0, pkt_err},   64'd6);
        check("timeout_pid",   {60'd0, pkt_pid},   64'd0);
        stop_rx();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
